// File: rtl/branch_history_table_if.sv
// Lookup / resolve / pattern-table-update bundle for the branch history table.
interface branch_history_table_if #(
    parameter int IDX_WIDTH  = 3,
    parameter int HIST_WIDTH = 3,
    parameter int PC_WIDTH   = 10
);
    logic [PC_WIDTH-1:0]   lookup_pc;
    logic                  hit;
    logic [HIST_WIDTH-1:0] prev_history;
    logic                  resolve_valid;
    logic [PC_WIDTH-1:0]   resolve_pc;
    logic                  resolve_taken;
    logic                  we;
    logic [PC_WIDTH-1:0]   old_pc;
    logic                  branch_taken;
    logic [HIST_WIDTH-1:0] update_history;
    logic                  evict;
    logic [IDX_WIDTH-1:0]  evict_idx;

    modport master (
        output lookup_pc, resolve_valid, resolve_pc, resolve_taken,
        input  hit, prev_history, we, old_pc, branch_taken, update_history,
               evict, evict_idx
    );

    modport slave (
        input  lookup_pc, resolve_valid, resolve_pc, resolve_taken,
        output hit, prev_history, we, old_pc, branch_taken, update_history,
               evict, evict_idx
    );
endinterface

// File: rtl/branch_history_table.sv
// Local-history table (first level of a two-level predictor), fully associative on PC tag.
// Optional macro BHT_BYPASS_EN forwards a same-cycle resolve into the lookup result.
module branch_history_table #(
    parameter int ENTRIES    = 8,
    parameter int IDX_WIDTH  = 3,
    parameter int HIST_WIDTH = 3,
    parameter int PC_WIDTH   = 10
) (
    input logic                    clk,
    input logic                    rst,
    branch_history_table_if.slave  bus
);
    logic [ENTRIES-1:0]                 valid;
    logic [ENTRIES-1:0][PC_WIDTH-1:0]   tag;
    logic [ENTRIES-1:0][HIST_WIDTH-1:0] hist;
    logic [IDX_WIDTH-1:0]               rr_ptr;

    logic [ENTRIES-1:0]    lk_match, rs_match;
    logic                  lk_hit, rs_hit, free_any;
    logic [HIST_WIDTH-1:0] lk_hist, rs_hist, shifted, new_hist;
    logic [HIST_WIDTH:0]   shift_ext;
    logic [IDX_WIDTH-1:0]  rs_idx, free_idx, victim;

    logic                  we_q, taken_q, evict_q;
    logic [PC_WIDTH-1:0]   old_pc_q;
    logic [HIST_WIDTH-1:0] uh_q;
    logic [IDX_WIDTH-1:0]  evict_idx_q;

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_cmp
            assign lk_match[g] = valid[g] && (tag[g] == bus.lookup_pc);
            assign rs_match[g] = valid[g] && (tag[g] == bus.resolve_pc);
        end
    endgenerate

    // Tags are unique, so match vectors are one-hot and an OR-reduce selects.
    always_comb begin
        lk_hist  = '0;
        rs_hist  = '0;
        rs_idx   = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_match[i]) lk_hist = lk_hist | hist[i];
            if (rs_match[i]) begin
                rs_hist = rs_hist | hist[i];
                rs_idx  = rs_idx | IDX_WIDTH'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign lk_hit    = |lk_match;
    assign rs_hit    = |rs_match;
    assign shift_ext = {rs_hist, bus.resolve_taken};
    assign shifted   = shift_ext[HIST_WIDTH-1:0];
    assign new_hist  = rs_hit ? shifted : HIST_WIDTH'(bus.resolve_taken);
    assign victim    = free_any ? free_idx : rr_ptr;

`ifdef BHT_BYPASS_EN
    logic fwd;
    assign fwd              = bus.resolve_valid && (bus.resolve_pc == bus.lookup_pc);
    assign bus.hit          = lk_hit | fwd;
    assign bus.prev_history = fwd ? new_hist : lk_hist;
`else
    assign bus.hit          = lk_hit;
    assign bus.prev_history = lk_hist;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            tag         <= '0;
            hist        <= '0;
            rr_ptr      <= '0;
            we_q        <= 1'b0;
            taken_q     <= 1'b0;
            evict_q     <= 1'b0;
            old_pc_q    <= '0;
            uh_q        <= '0;
            evict_idx_q <= '0;
        end else begin
            we_q    <= bus.resolve_valid;
            evict_q <= 1'b0;
            if (bus.resolve_valid) begin
                old_pc_q <= bus.resolve_pc;
                taken_q  <= bus.resolve_taken;
                if (rs_hit) begin
                    uh_q         <= rs_hist;
                    hist[rs_idx] <= shifted;
                end else begin
                    uh_q          <= '0;
                    valid[victim] <= 1'b1;
                    tag[victim]   <= bus.resolve_pc;
                    hist[victim]  <= new_hist;
                    // Round-robin only advances when a live entry is displaced.
                    if (!free_any) begin
                        evict_q     <= 1'b1;
                        evict_idx_q <= rr_ptr;
                        rr_ptr      <= rr_ptr + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.we             = we_q;
    assign bus.old_pc         = old_pc_q;
    assign bus.branch_taken   = taken_q;
    assign bus.update_history = uh_q;
    assign bus.evict          = evict_q;
    assign bus.evict_idx      = evict_idx_q;
endmodule

// File: tb/tb_branch_history_table.sv
// Directed table plus randomized traffic against an array-based model of the history table.
module tb_branch_history_table;
    localparam int ENTRIES = 8, IDX_W = 3, HIST_W = 3, PC_W = 10;
    localparam int MASK = (1 << HIST_W) - 1;
`ifdef BHT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_history_table_if #(.IDX_WIDTH(IDX_W), .HIST_WIDTH(HIST_W), .PC_WIDTH(PC_W)) bus ();

    branch_history_table #(.ENTRIES(ENTRIES), .IDX_WIDTH(IDX_W), .HIST_WIDTH(HIST_W),
                           .PC_WIDTH(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, failures = 0;

    // Reference model state
    bit m_valid[ENTRIES];
    int m_tag[ENTRIES];
    int m_hist[ENTRIES];
    int m_rr;
    int m_we, m_old, m_bt, m_uh, m_ev, m_evi;
    logic [31:0] s_hit, s_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find(input int pc);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_hist[i] = 0;
        end
        m_rr = 0; m_we = 0; m_old = 0; m_bt = 0; m_uh = 0; m_ev = 0; m_evi = 0;
    endtask

    task automatic model_resolve(input bit rv, input int pc, input bit t);
        int k, v;
        m_we = rv; m_ev = 0;
        if (!rv) return;
        m_old = pc; m_bt = t;
        k = find(pc);
        if (k >= 0) begin
            m_uh = m_hist[k];
            m_hist[k] = ((m_hist[k] * 2) + t) % (MASK + 1);
        end else begin
            m_uh = 0;
            v = -1;
            for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) v = i;
            if (v < 0) begin
                v = m_rr; m_ev = 1; m_evi = m_rr; m_rr = (m_rr + 1) % ENTRIES;
            end
            m_valid[v] = 1; m_tag[v] = pc; m_hist[v] = t;
        end
    endtask

    // One cycle: drive, check lookup, clock, check update packet.
    task automatic step(input bit r, input bit rv, input int pc, input bit t, input int lk);
        int k, e_hit, e_prev;
        rst = r;
        bus.resolve_valid = rv; bus.resolve_pc = pc[PC_W-1:0];
        bus.resolve_taken = t;  bus.lookup_pc = lk[PC_W-1:0];
        #1;
        k = find(lk);
        e_hit  = (k >= 0);
        e_prev = (k >= 0) ? m_hist[k] : 0;
        if (BYP && rv && pc == lk) begin
            k = find(pc);
            e_hit  = 1;
            e_prev = (k >= 0) ? ((m_hist[k] * 2) + t) % (MASK + 1) : t;
        end
        s_hit = 32'(bus.hit); s_prev = 32'(bus.prev_history);
        chk("hit", s_hit, e_hit);
        chk("prev_history", s_prev, e_prev);
        @(posedge clk);
        if (r) model_reset(); else model_resolve(rv, pc, t);
        #1;
        chk("we", bus.we, m_we);
        chk("old_pc", bus.old_pc, m_old);
        chk("branch_taken", bus.branch_taken, m_bt);
        chk("update_history", bus.update_history, m_uh);
        chk("evict", bus.evict, m_ev);
        chk("evict_idx", bus.evict_idx, m_evi);
    endtask

    typedef struct {
        bit r; bit rv; int pc; bit t; int lk;
        int hit; int prev; int we; int uh; int ev; int evi;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit rv, int pc, bit t, int lk,
                                int hit, int prev, int we, int uh, int ev, int evi);
        vec_t v;
        v.r = r; v.rv = rv; v.pc = pc; v.t = t; v.lk = lk;
        v.hit = hit; v.prev = prev; v.we = we; v.uh = uh; v.ev = ev; v.evi = evi;
        return v;
    endfunction

    initial begin
        // first allocate + T,N,T history walk of 0x010
        tbl.push_back(mk(0, 1, 'h010, 1, 'h3FF, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h010, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h010, 1, 'h3FF, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h010, 0, 'h3FF, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 'h010, 1, 'h3FF, 0, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h010, 1, 5, 0, 6, 0, 0));
        // reset wins over a concurrent resolve
        tbl.push_back(mk(1, 1, 'h010, 1, 'h3FF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h010, 0, 0, 0, 0, 0, 0));
        // same-cycle lookup and resolve
        tbl.push_back(mk(0, 1, 'h010, 1, 'h3FF, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h010, 0, 'h010, 1, BYP ? 2 : 1, 1, 1, 0, 0));
        // fill and evict
        tbl.push_back(mk(1, 0, 'h000, 0, 'h3FF, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, 'h100 + k, k[0], 'h3FF, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h200, 0, 'h3FF, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h201, 1, 'h3FF, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h100, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h101, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h107, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h201, 1, 1, 0, 0, 0, 1));
        // allocate while looking up the same PC
        tbl.push_back(mk(0, 1, 'h300, 1, 'h300, BYP ? 1 : 0, BYP ? 1 : 0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h300, 1, 1, 0, 0, 0, 2));

        rst = 1'b1;
        bus.resolve_valid = 1'b0; bus.resolve_pc = '0; bus.resolve_taken = 1'b0;
        bus.lookup_pc = 10'h010;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_hit", bus.hit, 0);
        chk("reset_prev_history", bus.prev_history, 0);
        chk("reset_we", bus.we, 0);
        chk("reset_old_pc", bus.old_pc, 0);
        chk("reset_branch_taken", bus.branch_taken, 0);
        chk("reset_update_history", bus.update_history, 0);
        chk("reset_evict", bus.evict, 0);
        chk("reset_evict_idx", bus.evict_idx, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].rv, tbl[i].pc, tbl[i].t, tbl[i].lk);
            chk($sformatf("vec%0d_hit", i), s_hit, tbl[i].hit);
            chk($sformatf("vec%0d_prev", i), s_prev, tbl[i].prev);
            chk($sformatf("vec%0d_we", i), bus.we, tbl[i].we);
            chk($sformatf("vec%0d_uh", i), bus.update_history, tbl[i].uh);
            chk($sformatf("vec%0d_evict", i), bus.evict, tbl[i].ev);
            chk($sformatf("vec%0d_evict_idx", i), bus.evict_idx, tbl[i].evi);
        end

        // random traffic over a pool larger than the table to force evictions
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 800; n++) begin
            bit r, rv, t;
            int pc, lk;
            r  = ($urandom_range(0, 79) == 0);
            rv = ($urandom_range(0, 9) < 7);
            t  = $urandom_range(0, 1);
            pc = 'h3C0 + $urandom_range(0, 11);
            lk = ($urandom_range(0, 3) == 0) ? pc : 'h3C0 + $urandom_range(0, 15);
            step(r, rv, pc, t, lk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
